// File: rtl/inv_round_pkg.sv
// AES inverse-cipher constants and GF(2^8) helpers shared by the decryption round datapath.
package aes_pkg;

  localparam int unsigned STATE_W = 128;
  localparam int unsigned NB      = 4;
  localparam int unsigned BYTES   = STATE_W / 8;

  // Inverse S-box, entry 0 in the top byte.
  localparam logic [2047:0] INV_SBOX_BITS = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX_BITS[(11'd255 - 11'(b)) * 11'd8 +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul11(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul13(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul14(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  // LSB position of state byte (row, col); byte 0 sits in the top 8 bits.
  function automatic int unsigned byte_lsb(input int unsigned row, input int unsigned col);
    return (BYTES - 1 - (col * NB + row)) * 8;
  endfunction

endpackage

// File: rtl/inv_round_if.sv
// Beat/key input and round-result output bundle of the inverse round.
interface inv_round_if #(
  parameter int unsigned DATA_W = 128
);
  logic              data_valid_in;
  logic              key_valid_in;
  logic              last_round;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] round_key;
  logic              valid_out;
  logic [DATA_W-1:0] data_out;
  logic              key_err;

  modport master (
    output data_valid_in, key_valid_in, last_round, data_in, round_key,
    input  valid_out, data_out, key_err
  );

  modport slave (
    input  data_valid_in, key_valid_in, last_round, data_in, round_key,
    output valid_out, data_out, key_err
  );
endinterface

// File: rtl/inv_round_inv_mix_column.sv
// InvMixColumns on one 32-bit column (row 0 in the top byte).
module inv_mix_column
  import aes_pkg::*;
(
  input  logic [31:0] col,
  output logic [31:0] mixed_c
);
  logic [7:0] a0, a1, a2, a3;

  assign a0 = col[31:24];
  assign a1 = col[23:16];
  assign a2 = col[15:8];
  assign a3 = col[7:0];

  assign mixed_c = {
    gf_mul14(a0) ^ gf_mul11(a1) ^ gf_mul13(a2) ^ gf_mul9(a3),
    gf_mul9(a0)  ^ gf_mul14(a1) ^ gf_mul11(a2) ^ gf_mul13(a3),
    gf_mul13(a0) ^ gf_mul9(a1)  ^ gf_mul14(a2) ^ gf_mul11(a3),
    gf_mul11(a0) ^ gf_mul13(a1) ^ gf_mul9(a2)  ^ gf_mul14(a3)
  };
endmodule

// File: rtl/inv_round.sv
// One AES decryption round, 4-stage pipeline: InvShiftRows, InvSubBytes, AddRoundKey,
// InvMixColumns (bypassed on the final round). One beat per cycle, no backpressure.
module inv_round
  import aes_pkg::*;
#(
  parameter int unsigned DATA_W = STATE_W
) (
  input  logic       clk,
  input  logic       reset,
  inv_round_if.slave bus
);
  logic              key_loaded;
  logic [DATA_W-1:0] key_hold;
  logic              s1_valid, s2_valid, s3_valid;
  logic              s1_last, s2_last, s3_last;
  logic [DATA_W-1:0] s1_data, s1_key, s2_data, s2_key, s3_data;
  logic              valid_q, key_err_q;
  logic [DATA_W-1:0] dout_q;

  logic              accept_c, drop_c;
  logic [DATA_W-1:0] eff_key_c, isr_c, isb_c, imc_c;

  // A fresh key wins over the held one for the beat presented alongside it.
  assign eff_key_c = bus.key_valid_in ? bus.round_key : key_hold;
  assign accept_c  = bus.data_valid_in & (bus.key_valid_in | key_loaded);
  assign drop_c    = bus.data_valid_in & ~bus.key_valid_in & ~key_loaded;

  // InvShiftRows: row r rotates right by r byte positions.
  always_comb begin
    isr_c = '0;
    for (int unsigned r = 0; r < NB; r++) begin
      for (int unsigned c = 0; c < NB; c++) begin
        isr_c[byte_lsb(r, (c + r) % NB) +: 8] = bus.data_in[byte_lsb(r, c) +: 8];
      end
    end
  end

  always_comb begin
    isb_c = '0;
    for (int unsigned b = 0; b < BYTES; b++) begin
      isb_c[b*8 +: 8] = inv_sbox(s1_data[b*8 +: 8]);
    end
  end

  for (genvar c = 0; c < NB; c++) begin : g_col
    inv_mix_column u_col (
      .col     (s3_data[(NB-1-c)*32 +: 32]),
      .mixed_c (imc_c[(NB-1-c)*32 +: 32])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_hold   <= '0;
      key_loaded <= 1'b0;
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      s3_valid   <= 1'b0;
      s1_last    <= 1'b0;
      s2_last    <= 1'b0;
      s3_last    <= 1'b0;
      s1_data    <= '0;
      s1_key     <= '0;
      s2_data    <= '0;
      s2_key     <= '0;
      s3_data    <= '0;
      valid_q    <= 1'b0;
      dout_q     <= '0;
      key_err_q  <= 1'b0;
    end else begin
      if (bus.key_valid_in) begin
        key_hold   <= bus.round_key;
        key_loaded <= 1'b1;
      end
      key_err_q <= drop_c;

      s1_valid <= accept_c;
      if (accept_c) begin
        s1_data <= isr_c;
        s1_key  <= eff_key_c;
        s1_last <= bus.last_round;
      end

      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= isb_c;
        s2_key  <= s1_key;
        s2_last <= s1_last;
      end

      s3_valid <= s2_valid;
      if (s2_valid) begin
        s3_data <= s2_data ^ s2_key;
        s3_last <= s2_last;
      end

      valid_q <= s3_valid;
      if (s3_valid) dout_q <= s3_last ? s3_data : imc_c;
    end
  end

  assign bus.valid_out = valid_q;
  assign bus.data_out  = dout_q;
  assign bus.key_err   = key_err_q;
endmodule
